// File: rtl/drum_pkg.sv
// Shared types, default sizing and saturation helper for the drum column solver.
package drum_pkg;

   localparam int DEF_WIDTH   = 18;
   localparam int DEF_FRAC    = 17;
   localparam int DEF_RHO_MAX = (48 << 17) / 100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Symmetric clamp to +/-(2^(w-1)-1); the most negative code is never returned.
   function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
      logic signed [63:0] lim;
      lim = (64'sd1 <<< (w - 1)) - 64'sd1;
      if (x > lim) begin
         sat = lim;
      end else if (x < -lim) begin
         sat = -lim;
      end else begin
         sat = x;
      end
   endfunction

endpackage

// File: rtl/drum_column_solver_if.sv
// Row-indexed side-neighbour request port between a column solver and its neighbour source.
interface drum_column_solver_if
   import drum_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ROWS  = 32
);
   logic                      nb_req;
   logic [$clog2(ROWS)-1:0]   nb_row;
   logic                      nb_valid;
   logic signed [WIDTH-1:0]   nb_left;
   logic signed [WIDTH-1:0]   nb_right;

   modport master (output nb_req, nb_row, input nb_valid, nb_left, nb_right);
   modport slave  (input nb_req, nb_row, output nb_valid, nb_left, nb_right);
endinterface

// File: rtl/drum_node_datapath.sv
// Single-node finite-difference kernel: laplacian, rho-scaled coupling, damping, saturation.
module drum_node_datapath
   import drum_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int FRAC       = DEF_FRAC,
   parameter int DAMP_SHIFT = 10,
   parameter int RHO_MAX    = DEF_RHO_MAX
) (
   input  logic signed [WIDTH-1:0] up,
   input  logic signed [WIDTH-1:0] down,
   input  logic signed [WIDTH-1:0] left,
   input  logic signed [WIDTH-1:0] right,
   input  logic signed [WIDTH-1:0] mid,
   input  logic signed [WIDTH-1:0] old,
   input  logic        [WIDTH-1:0] rho,
   output logic signed [WIDTH-1:0] u2
);
   localparam int IW = WIDTH + 3;
   localparam int PW = 2 * WIDTH + 2;
   localparam logic [WIDTH-1:0] RHO_LIM = WIDTH'(RHO_MAX);

   logic signed [IW-1:0]    sum;
   logic signed [WIDTH-1:0] lap;
   logic signed [WIDTH:0]   r_eff;
   logic signed [PW-1:0]    prod_full;
   logic signed [IW-1:0]    prod;
   logic signed [IW-1:0]    old_damp;
   logic signed [IW-1:0]    t3;
   logic signed [IW-1:0]    t4;

   // rho is an unsigned magnitude, so it enters the multiply with a zero sign bit
   always_comb begin
      sum = IW'(up) + IW'(down) + IW'(left) + IW'(right) - (IW'(mid) <<< 2);
      lap = WIDTH'(sat(64'(sum), WIDTH));
      if (rho > RHO_LIM) begin
         r_eff = {1'b0, RHO_LIM};
      end else begin
         r_eff = {1'b0, rho};
      end
      prod_full = PW'(lap) * PW'(r_eff);
      prod      = IW'(prod_full >>> FRAC);
      old_damp  = IW'(old) - (IW'(old) >>> DAMP_SHIFT);
      t3        = prod + (IW'(mid) <<< 1) - old_damp;
      t4        = t3 - (t3 >>> DAMP_SHIFT);
      u2        = WIDTH'(sat(64'(t4), WIDTH));
   end

endmodule

// File: rtl/drum_column_solver.sv
// Time-multiplexed wave-equation solver for one membrane column; one row per accepted cycle.
module drum_column_solver
   import drum_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int FRAC       = DEF_FRAC,
   parameter int ROWS       = 32,
   parameter int DAMP_SHIFT = 10,
   parameter int RHO_MAX    = DEF_RHO_MAX,
   parameter int TAP_ROW    = ROWS / 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      ld_valid,
   input  logic [$clog2(ROWS)-1:0]   ld_addr,
   input  logic signed [WIDTH-1:0]   ld_data,
   output logic                      ld_ready,
   input  logic [WIDTH-1:0]          rho,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   drum_column_solver_if.master      nb,
   output logic                      out_valid,
   output logic [$clog2(ROWS)-1:0]   out_row,
   output logic signed [WIDTH-1:0]   out_data,
   output logic signed [WIDTH-1:0]   tap
);
   localparam int RW = $clog2(ROWS);
   localparam logic [RW-1:0] LAST    = RW'(ROWS - 1);
   localparam logic [RW-1:0] TAP_IDX = RW'(TAP_ROW);

   state_t                  state;
   state_t                  next_state;
   logic [RW-1:0]           row;
   logic [RW-1:0]           dn_idx;
   logic signed [WIDTH-1:0] u0 [ROWS];
   logic signed [WIDTH-1:0] u1 [ROWS];
   logic signed [WIDTH-1:0] prev_mid;
   logic signed [WIDTH-1:0] down;
   logic signed [WIDTH-1:0] u2;
   logic                    step;

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN; else next_state = IDLE;
         RUN:     if (step && row == LAST) next_state = DONE; else next_state = RUN;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      ld_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      nb.nb_req = 1'b0;
      case (state)
         IDLE:    ld_ready = 1'b1;
         RUN: begin
            busy      = 1'b1;
            nb.nb_req = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ld_ready = 1'b0;
      endcase
   end

   assign nb.nb_row = row;
   assign step      = (state == RUN) && nb.nb_valid;
   assign dn_idx    = (row == LAST) ? row : row + RW'(1);
   assign down      = (row == LAST) ? {WIDTH{1'b0}} : u1[dn_idx];

   drum_node_datapath #(
      .WIDTH      (WIDTH),
      .FRAC       (FRAC),
      .DAMP_SHIFT (DAMP_SHIFT),
      .RHO_MAX    (RHO_MAX)
   ) u_kernel (
      .up    (prev_mid),
      .down  (down),
      .left  (nb.nb_left),
      .right (nb.nb_right),
      .mid   (u1[row]),
      .old   (u0[row]),
      .rho   (rho),
      .u2    (u2)
   );

   // column storage: host loads while idle, row write-back while running
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ROWS; i++) begin
            u0[i] <= {WIDTH{1'b0}};
            u1[i] <= {WIDTH{1'b0}};
         end
      end else if (state == IDLE && ld_valid) begin
         u0[ld_addr] <= ld_data;
         u1[ld_addr] <= ld_data;
      end else if (step) begin
         u0[row] <= u1[row];
         u1[row] <= u2;
      end
   end

   // sweep counter, up-neighbour carry and registered result/tap outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row       <= {RW{1'b0}};
         prev_mid  <= {WIDTH{1'b0}};
         out_valid <= 1'b0;
         out_row   <= {RW{1'b0}};
         out_data  <= {WIDTH{1'b0}};
         tap       <= {WIDTH{1'b0}};
      end else begin
         out_valid <= step;
         if (state == IDLE && start) begin
            row      <= {RW{1'b0}};
            prev_mid <= {WIDTH{1'b0}};
         end else if (step) begin
            row      <= (row == LAST) ? {RW{1'b0}} : row + RW'(1);
            prev_mid <= u1[row];
            out_row  <= row;
            out_data <= u2;
            if (row == TAP_IDX) begin
               tap <= u2;
            end
         end
      end
   end

endmodule

// File: tb/tb_drum_column_solver.sv
// Scoreboard bench for drum_column_solver: an independent model predicts each row, the monitor pops and compares.
module tb_drum_column_solver;
   localparam int W     = 18;
   localparam int ROWS  = 8;
   localparam int TAPR  = 4;
   localparam int SMAX  = 131071;
   localparam int RMAX  = (48 << 17) / 100;

   typedef struct {
      int     row;
      longint data;
   } exp_t;

   logic                clock = 1'b0;
   logic                reset;
   logic                ld_valid;
   logic [2:0]          ld_addr;
   logic signed [W-1:0] ld_data;
   logic                ld_ready;
   logic [W-1:0]        rho;
   logic                start;
   logic                busy;
   logic                done;
   logic                out_valid;
   logic [2:0]          out_row;
   logic signed [W-1:0] out_data;
   logic signed [W-1:0] tap;

   drum_column_solver_if #(.WIDTH(W), .ROWS(ROWS)) nbif ();

   drum_column_solver #(
      .WIDTH(W), .FRAC(17), .ROWS(ROWS), .DAMP_SHIFT(10), .RHO_MAX(RMAX), .TAP_ROW(TAPR)
   ) dut (
      .clock(clock), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ready(ld_ready), .rho(rho), .start(start), .busy(busy), .done(done), .nb(nbif),
      .out_valid(out_valid), .out_row(out_row), .out_data(out_data), .tap(tap)
   );

   always #5 clock = ~clock;

   int     n_checks = 0;
   int     n_errors = 0;
   int     cyc = 0;
   int     done_cnt = 0;
   int     done_cyc = 0;
   int     last_lat = 0;
   longint m_u0 [ROWS];
   longint m_u1 [ROWS];
   longint nl [ROWS];
   longint nr [ROWS];
   longint obs [ROWS];
   exp_t   sb [$];

   task automatic check_val(input string tag, input longint got, input longint want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   function automatic longint msat(input longint x);
      if (x > SMAX) return longint'(SMAX);
      if (x < -SMAX) return -longint'(SMAX);
      return x;
   endfunction

   function automatic longint node(input longint up, input longint dn, input longint l,
                                   input longint r, input longint mid, input longint old,
                                   input longint rh);
      longint lap, re, prod, t3, t4;
      lap  = msat(up + dn + l + r - 4 * mid);
      re   = (rh > RMAX) ? longint'(RMAX) : rh;
      prod = (lap * re) >>> 17;
      t3   = prod + 2 * mid - (old - (old >>> 10));
      t4   = t3 - (t3 >>> 10);
      return msat(t4);
   endfunction

   function automatic longint rnd();
      return longint'($urandom_range(0, 2 * SMAX)) - longint'(SMAX);
   endfunction

   always @(posedge clock) cyc++;

   // monitor: count done pulses, pop scoreboard on every output row
   always @(negedge clock) begin : mon
      exp_t e;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (out_valid) begin
         check_val("out_range", longint'(out_data >= -SMAX), 1);
         check_val("sb_has_entry", longint'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("out_row", longint'(out_row), longint'(e.row));
            check_val("out_data", longint'(out_data), e.data);
            obs[out_row] = out_data;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_row(input int a, input longint d);
      ld_valid = 1'b1;
      ld_addr  = 3'(a);
      ld_data  = 18'(d);
      tick();
      ld_valid = 1'b0;
      m_u0[a]  = d;
      m_u1[a]  = d;
   endtask

   task automatic model_step(input longint rh);
      longint nu [ROWS];
      for (int r = 0; r < ROWS; r++) begin
         nu[r] = node((r == 0) ? 0 : m_u1[r-1], (r == ROWS - 1) ? 0 : m_u1[r+1],
                      nl[r], nr[r], m_u1[r], m_u0[r], rh);
         sb.push_back('{row: r, data: nu[r]});
      end
      for (int r = 0; r < ROWS; r++) begin
         m_u0[r] = m_u1[r];
         m_u1[r] = nu[r];
      end
   endtask

   task automatic run_step(input longint rh, input int stall_mode, input int abort_row,
                           input bit noise, input bit same_ld, input int la, input longint lv);
      int er, t0, dc0, budget;
      bit v;
      if (same_ld) begin
         ld_valid = 1'b1;
         ld_addr  = 3'(la);
         ld_data  = 18'(lv);
         m_u0[la] = lv;
         m_u1[la] = lv;
      end
      rho = 18'(rh);
      model_step(rh);
      dc0   = done_cnt;
      start = 1'b1;
      t0    = cyc;
      tick();
      start    = 1'b0;
      ld_valid = 1'b0;
      check_val("busy_run", longint'(busy), 1);
      check_val("ld_ready_run", longint'(ld_ready), 0);
      er = 0;
      budget = 0;
      while (er < ROWS && budget < 8 * ROWS) begin
         if (abort_row >= 0 && er == abort_row) break;
         check_val("nb_row", longint'(nbif.nb_row), longint'(er));
         check_val("nb_req", longint'(nbif.nb_req), 1);
         case (stall_mode)
            0:       v = 1'b1;
            1:       v = (budget % 2 == 1);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         nbif.nb_valid = v;
         nbif.nb_left  = 18'(nl[er]);
         nbif.nb_right = 18'(nr[er]);
         if (noise) begin
            start    = ($urandom_range(0, 1) == 1);
            ld_valid = 1'b1;
            ld_addr  = 3'($urandom_range(0, ROWS - 1));
            ld_data  = 18'(rnd());
         end
         tick();
         if (v) er++;
         budget++;
      end
      nbif.nb_valid = 1'b0;
      start    = 1'b0;
      ld_valid = 1'b0;
      if (abort_row >= 0) begin
         reset = 1'b1;
         #2;
         check_val("abort_busy", longint'(busy), 0);
         check_val("abort_done", longint'(done), 0);
         check_val("abort_out_valid", longint'(out_valid), 0);
         check_val("abort_out_data", longint'(out_data), 0);
         check_val("abort_tap", longint'(tap), 0);
         check_val("abort_nb_req", longint'(nbif.nb_req), 0);
         tick();
         reset = 1'b0;
         tick();
         check_val("abort_ld_ready", longint'(ld_ready), 1);
         tick();
         tick();
         check_val("abort_no_done", longint'(done_cnt - dc0), 0);
         sb.delete();
         for (int r = 0; r < ROWS; r++) begin
            m_u0[r] = 0;
            m_u1[r] = 0;
         end
         return;
      end
      check_val("row_budget", longint'(er), longint'(ROWS));
      tick();
      tick();
      check_val("done_count", longint'(done_cnt - dc0), 1);
      last_lat = done_cyc - t0;
      check_val("done_latency", longint'(last_lat), longint'(budget + 1));
      check_val("sb_drained", longint'(sb.size()), 0);
      check_val("tap", longint'(tap), m_u1[TAPR]);
      check_val("busy_idle", longint'(busy), 0);
      check_val("ld_ready_idle", longint'(ld_ready), 1);
   endtask

   task automatic load_impulse();
      for (int r = 0; r < ROWS; r++) begin
         load_row(r, (r == 4) ? 64'sh8000 : 64'sd0);
         nl[r] = 0;
         nr[r] = 0;
      end
   endtask

   task automatic check_impulse(input string tag);
      check_val({tag, "_row3"}, obs[3], 64'sh1993);
      check_val({tag, "_row4"}, obs[4], 64'sh19B4);
      check_val({tag, "_row5"}, obs[5], 64'sh1993);
      check_val({tag, "_row0"}, obs[0], 0);
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      ld_valid = 1'b0; ld_addr = 3'd0; ld_data = 18'sd0;
      rho = 18'd0; start = 1'b0;
      nbif.nb_valid = 1'b0; nbif.nb_left = 18'sd0; nbif.nb_right = 18'sd0;
      for (int r = 0; r < ROWS; r++) begin
         m_u0[r] = 0; m_u1[r] = 0; nl[r] = 0; nr[r] = 0; obs[r] = 0;
      end
      tick();
      tick();
      reset = 1'b0;
      tick();
      check_val("rst_ld_ready", longint'(ld_ready), 1);
      check_val("rst_busy", longint'(busy), 0);
      check_val("rst_done", longint'(done), 0);
      check_val("rst_out_valid", longint'(out_valid), 0);
      check_val("rst_out_data", longint'(out_data), 0);
      check_val("rst_tap", longint'(tap), 0);
      check_val("rst_nb_req", longint'(nbif.nb_req), 0);

      // impulse, free-running then stalled
      load_impulse();
      run_step(64'sh6666, 0, -1, 1'b0, 1'b0, 0, 0);
      check_impulse("impulse");
      check_val("impulse_lat", longint'(last_lat), longint'(ROWS + 1));
      for (int r = 0; r < ROWS; r++) obs[r] = -1;
      load_impulse();
      run_step(64'sh6666, 1, -1, 1'b0, 1'b0, 0, 0);
      check_impulse("stall");
      check_val("stall_lat", longint'(last_lat), longint'(2 * ROWS + 1));

      // reset while processing row 5
      for (int r = 0; r < ROWS; r++) begin
         load_row(r, rnd());
         nl[r] = rnd();
         nr[r] = rnd();
      end
      run_step(64'sh6666, 0, 5, 1'b0, 1'b0, 0, 0);

      // rho above the clamp
      for (int r = 0; r < ROWS; r++) begin
         load_row(r, rnd());
         nl[r] = rnd();
         nr[r] = rnd();
      end
      run_step(64'sh1FFFF, 0, -1, 1'b0, 1'b0, 0, 0);

      // saturation at both rails
      for (int r = 0; r < ROWS; r++) begin
         load_row(r, 64'sh1FFFF);
         nl[r] = 64'sh1FFFF;
         nr[r] = 64'sh1FFFF;
      end
      run_step(longint'(RMAX), 0, -1, 1'b0, 1'b0, 0, 0);
      for (int r = 0; r < ROWS; r++) begin
         load_row(r, -64'sh1FFFF);
         nl[r] = -64'sh1FFFF;
         nr[r] = -64'sh1FFFF;
      end
      run_step(longint'(RMAX), 0, -1, 1'b0, 1'b0, 0, 0);

      // start/load noise during RUN, and load+start in one cycle
      run_step(64'sh4000, 2, -1, 1'b1, 1'b0, 0, 0);
      run_step(64'sh4000, 0, -1, 1'b0, 1'b1, 3, 64'sh0C000);

      // random steps
      for (int s = 0; s < 1000; s++) begin
         longint rh;
         if ($urandom_range(0, 3) == 0) begin
            for (int r = 0; r < ROWS; r++) begin
               if ($urandom_range(0, 1) == 1) load_row(r, rnd());
            end
         end
         for (int r = 0; r < ROWS; r++) begin
            nl[r] = rnd();
            nr[r] = rnd();
         end
         if ($urandom_range(0, 3) == 0) rh = longint'($urandom_range(RMAX + 1, 262143));
         else rh = longint'($urandom_range(0, RMAX));
         run_step(rh, int'($urandom_range(0, 2)), -1, ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, ROWS - 1)), rnd());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
